// File: rtl/md_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_stall_ctrl_pkg
// Purpose  : Shared opcode/funct constants and shadow-FSM state encoding for
//            the multiply/divide stall controller.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package md_stall_ctrl_pkg;

   // Primary opcode of R-type instructions
   localparam logic [5:0] c_OP_SPECIAL = 6'b000000;

   // Operations that start the multiply/divide unit
   localparam logic [5:0] c_FN_MULT    = 6'b011000;
   localparam logic [5:0] c_FN_MULTU   = 6'b011001;
   localparam logic [5:0] c_FN_DIV     = 6'b011010;
   localparam logic [5:0] c_FN_DIVU    = 6'b011011;

   // HI/LO accesses that must wait for an in-flight operation
   localparam logic [5:0] c_FN_MFHI    = 6'b010000;
   localparam logic [5:0] c_FN_MTHI    = 6'b010001;
   localparam logic [5:0] c_FN_MFLO    = 6'b010010;
   localparam logic [5:0] c_FN_MTLO    = 6'b010011;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MULT_WAIT = 2'd1,
      DIV_WAIT  = 2'd2
   } md_state_e;

endpackage : md_stall_ctrl_pkg
`default_nettype wire

// File: rtl/md_stall_ctrl_md_class_dec.sv
`default_nettype none
// ============================================================================
// Module   : md_class_dec
// Purpose  : Combinational classification of one instruction word into the
//            multiply/divide classes used by the stall controller.
// Ports    : instr_i        [31:0] instruction word
//            is_md_start_o         mult/multu/div/divu
//            is_md_access_o        mfhi/mthi/mflo/mtlo
//            is_div_o              div/divu (subset of is_md_start_o)
// Revision : 1.0  initial release
// ============================================================================
module md_class_dec
   import md_stall_ctrl_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic        is_md_start_o,
   output logic        is_md_access_o,
   output logic        is_div_o
);

   logic w_special;
   assign w_special = (instr_i[31:26] == c_OP_SPECIAL);

   always_comb begin
      is_md_start_o  = 1'b0;
      is_md_access_o = 1'b0;
      if (w_special) begin
         case (instr_i[5:0])
            c_FN_MULT, c_FN_MULTU, c_FN_DIV, c_FN_DIVU: is_md_start_o  = 1'b1;
            c_FN_MFHI, c_FN_MTHI, c_FN_MFLO, c_FN_MTLO: is_md_access_o = 1'b1;
            default: ;
         endcase
      end
      // Within the start group, funct[1] separates div/divu from mult/multu
      is_div_o = is_md_start_o & instr_i[1];
   end

endmodule : md_class_dec
`default_nettype wire

// File: rtl/md_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : md_stall_ctrl
// Purpose  : Issue-side partner of the E-stage multiply/divide unit. Stalls
//            D-stage HI/LO-class instructions while an operation is in
//            flight, shadows the unit latency, flags handshake mismatches and
//            counts stall cycles (saturating).
// Ports    : clk, reset          clock, synchronous active-high reset
//            instr_D, instr_E    [31:0] D- and E-stage instructions
//            start_E, busy_E     handshake from the multiply/divide unit
//            stall_md            stall PC/F/D, bubble E (combinational)
//            md_pending          shadow FSM busy
//            pending_div         in-flight op is div/divu
//            proto_err           sticky handshake-mismatch flag
//            stall_cnt [CNT_W]   saturating stall-cycle count
// Revision : 1.0  initial release
// ============================================================================
module md_stall_ctrl
   import md_stall_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr_D,
   input  logic [31:0]      instr_E,
   input  logic             start_E,
   input  logic             busy_E,
   output logic             stall_md,
   output logic             md_pending,
   output logic             pending_div,
   output logic             proto_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int c_MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int c_CNT_BITS   = $clog2(c_MAX_CYCLES + 1);

   localparam logic [c_CNT_BITS-1:0] c_MULT_LOAD = c_CNT_BITS'(MULT_CYCLES);
   localparam logic [c_CNT_BITS-1:0] c_DIV_LOAD  = c_CNT_BITS'(DIV_CYCLES);
   localparam logic [c_CNT_BITS-1:0] c_ONE       = c_CNT_BITS'(1);

   // ------------------------------------------------------------------
   // Decode of both pipeline stages
   // ------------------------------------------------------------------
   logic w_d_start, w_d_access, w_d_div;
   logic w_e_start, w_e_access, w_e_div;

   md_class_dec u_dec_d (
      .instr_i        (instr_D),
      .is_md_start_o  (w_d_start),
      .is_md_access_o (w_d_access),
      .is_div_o       (w_d_div)
   );

   md_class_dec u_dec_e (
      .instr_i        (instr_E),
      .is_md_start_o  (w_e_start),
      .is_md_access_o (w_e_access),
      .is_div_o       (w_e_div)
   );

   // D-stage div flag and E-stage access flag have no role here
   logic w_unused_dec;
   assign w_unused_dec = w_d_div ^ w_e_access;

   // ------------------------------------------------------------------
   // Shadow FSM with registered status outputs
   // ------------------------------------------------------------------
   md_state_e             state_q;
   logic [c_CNT_BITS-1:0] cnt_q;
   logic                  md_pending_q;
   logic                  pending_div_q;

   logic w_d_class;
   logic w_start_ok;
   logic w_err_now;

   assign w_d_class  = w_d_start | w_d_access;
   assign w_start_ok = start_E & w_e_start;

   // A second start while busy (last start wins), a start on a non-MD
   // instruction, or the unit's busy disagreeing with the shadow FSM
   assign w_err_now  = (start_E & ~w_e_start)
                     | (w_start_ok & md_pending_q)
                     | (md_pending_q != busy_E);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         md_pending_q  <= 1'b0;
         pending_div_q <= 1'b0;
      end else if (w_start_ok) begin
         md_pending_q <= 1'b1;
         if (w_e_div) begin
            state_q       <= DIV_WAIT;
            cnt_q         <= c_DIV_LOAD;
            pending_div_q <= 1'b1;
         end else begin
            state_q       <= MULT_WAIT;
            cnt_q         <= c_MULT_LOAD;
            pending_div_q <= 1'b0;
         end
      end else begin
         case (state_q)
            IDLE: ;
            MULT_WAIT, DIV_WAIT: begin
               if (cnt_q == c_ONE) begin
                  state_q       <= IDLE;
                  cnt_q         <= '0;
                  md_pending_q  <= 1'b0;
                  pending_div_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - c_ONE;
               end
            end
            default: begin
               state_q       <= IDLE;
               cnt_q         <= '0;
               md_pending_q  <= 1'b0;
               pending_div_q <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sticky protocol error
   // ------------------------------------------------------------------
   logic proto_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         proto_err_q <= 1'b0;
      end else if (w_err_now) begin
         proto_err_q <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Stall generation and saturating stall counter
   // ------------------------------------------------------------------
   logic             w_stall;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;

   assign w_stall = w_d_class & (start_E | busy_E | md_pending_q);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_md    = w_stall;
   assign md_pending  = md_pending_q;
   assign pending_div = pending_div_q;
   assign proto_err   = proto_err_q;
   assign stall_cnt   = stall_cnt_q;

endmodule : md_stall_ctrl
`default_nettype wire
